// File: rtl/pw_bit_frame_tx_if.sv
// AXI-Stream channel bundles used by pw_bit_frame_tx: a data channel carrying tlast
// and a config channel without it.
interface pw_axis_data_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, tlast, tvalid, input tready);
  modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

interface pw_axis_cfg_if #(
  parameter int unsigned DW = 16
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, tvalid, input tready);
  modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/pw_bit_frame_tx.sv
// Pulse-width bit encoder: serialises AXIS words onto txd, one fixed-period symbol per bit,
// with chained words, a post-tlast gap and underrun reporting. All outputs are registered.
module pw_bit_frame_tx #(
  parameter int unsigned COUNTER_WIDTH        = 16,
  parameter int unsigned DATA_AXIS_DATA_WIDTH = 8,
  parameter int unsigned CFG_AXIS_DATA_WIDTH  = COUNTER_WIDTH,
  parameter bit          MSB_FIRST            = 1'b1,
  parameter bit          IDLE_LEVEL           = 1'b0
) (
  input  logic          aclk,
  input  logic          aresetn,
  pw_axis_data_if.slave data_s_axis,
  pw_axis_cfg_if.slave  cfg_period_s_axis,
  pw_axis_cfg_if.slave  cfg_duty_hi_s_axis,
  pw_axis_cfg_if.slave  cfg_duty_lo_s_axis,
  pw_axis_cfg_if.slave  cfg_gap_s_axis,
  output logic          txd,
  output logic          busy,
  output logic          underrun
);

  localparam int unsigned CW  = COUNTER_WIDTH;
  localparam int unsigned CW1 = COUNTER_WIDTH + 1;
  localparam int unsigned DW  = DATA_AXIS_DATA_WIDTH;
  localparam int unsigned IW  = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIT  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] duty_hi_q, duty_hi_d;
  logic [CW-1:0] duty_lo_q, duty_lo_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] word_q, word_d;
  logic          last_q, last_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          underrun_q, underrun_d;
  logic          data_tready_q, data_tready_d;
  logic          cfg_tready_q, cfg_tready_d;

  logic          data_hs;
  logic          bit_end;
  logic          word_end;
  logic          gap_end;
  logic [IW-1:0] bit_pos_d;
  logic          cur_bit_d;
  logic [CW-1:0] duty_sel_d;

  // Only the low COUNTER_WIDTH bits of a config word are meaningful.
  function automatic logic [CW-1:0] cfg_val(input logic [CFG_AXIS_DATA_WIDTH-1:0] v);
    return v[CW-1:0];
  endfunction

  assign data_hs = data_s_axis.tvalid & data_tready_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      period_q      <= '0;
      duty_hi_q     <= '0;
      duty_lo_q     <= '0;
      gap_q         <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      word_q        <= '0;
      last_q        <= 1'b0;
      txd_q         <= IDLE_LEVEL;
      busy_q        <= 1'b0;
      underrun_q    <= 1'b0;
      data_tready_q <= 1'b0;
      cfg_tready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      duty_hi_q     <= duty_hi_d;
      duty_lo_q     <= duty_lo_d;
      gap_q         <= gap_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      word_q        <= word_d;
      last_q        <= last_d;
      txd_q         <= txd_d;
      busy_q        <= busy_d;
      underrun_q    <= underrun_d;
      data_tready_q <= data_tready_d;
      cfg_tready_q  <= cfg_tready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    duty_hi_d  = duty_hi_q;
    duty_lo_d  = duty_lo_q;
    gap_d      = gap_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    word_d     = word_q;
    last_d     = last_q;
    underrun_d = 1'b0;

    // The >= form keeps a zero period from running the counter through a wrap.
    bit_end  = ({1'b0, cnt_q} + CW1'(1)) >= {1'b0, period_q};
    word_end = bit_end && (idx_q == IW'(DW - 1));
    gap_end  = ({1'b0, cnt_q} + CW1'(1)) >= {1'b0, gap_q};

    if (cfg_period_s_axis.tvalid && cfg_tready_q)  period_d  = cfg_val(cfg_period_s_axis.tdata);
    if (cfg_duty_hi_s_axis.tvalid && cfg_tready_q) duty_hi_d = cfg_val(cfg_duty_hi_s_axis.tdata);
    if (cfg_duty_lo_s_axis.tvalid && cfg_tready_q) duty_lo_d = cfg_val(cfg_duty_lo_s_axis.tdata);
    if (cfg_gap_s_axis.tvalid && cfg_tready_q)     gap_d     = cfg_val(cfg_gap_s_axis.tdata);

    unique case (state_q)
      ST_IDLE: begin
        if (data_hs) begin
          state_d = ST_BIT;
          word_d  = data_s_axis.tdata;
          last_d  = data_s_axis.tlast;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_BIT: begin
        if (!bit_end) begin
          cnt_d = cnt_q + CW'(1);
        end else if (!word_end) begin
          idx_d = idx_q + IW'(1);
          cnt_d = '0;
        end else if (last_q) begin
          cnt_d   = '0;
          state_d = (gap_q != '0) ? ST_GAP : ST_IDLE;
        end else if (data_hs) begin
          word_d = data_s_axis.tdata;
          last_d = data_s_axis.tlast;
          idx_d  = '0;
          cnt_d  = '0;
        end else begin
          underrun_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_end) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs describe the cycle that follows this edge.
    bit_pos_d     = MSB_FIRST ? (IW'(DW - 1) - idx_d) : idx_d;
    cur_bit_d     = word_d[bit_pos_d];
    duty_sel_d    = cur_bit_d ? duty_hi_d : duty_lo_d;
    txd_d         = ((state_d == ST_BIT) && (cnt_d < duty_sel_d)) ? ~IDLE_LEVEL : IDLE_LEVEL;
    busy_d        = (state_d != ST_IDLE);
    cfg_tready_d  = (state_d == ST_IDLE);
    data_tready_d = ((state_d == ST_IDLE) && (period_d != '0)) ||
                    ((state_d == ST_BIT) && !last_d && (idx_d == IW'(DW - 1)) &&
                     (({1'b0, cnt_d} + CW1'(1)) >= {1'b0, period_d}));
  end

  assign txd                       = txd_q;
  assign busy                      = busy_q;
  assign underrun                  = underrun_q;
  assign data_s_axis.tready        = data_tready_q;
  assign cfg_period_s_axis.tready  = cfg_tready_q;
  assign cfg_duty_hi_s_axis.tready = cfg_tready_q;
  assign cfg_duty_lo_s_axis.tready = cfg_tready_q;
  assign cfg_gap_s_axis.tready     = cfg_tready_q;

endmodule

// File: doc/pw_bit_frame_tx.md
Name: pw_bit_frame_tx

Overview:
- Pulse-width bit encoder: serialises AXI-Stream data words onto a single `txd` line, one fixed-period symbol per bit.
- A '1' bit drives the active level for `duty_hi` cycles; a '0' bit drives it for `duty_lo` cycles. The rest of each period sits at the idle level.
- Successor to the single-word pw_bit cell. Adds selectable bit order, selectable idle polarity, gapless back-to-back words, a programmable inter-frame gap after `tlast`, underrun reporting, and config locked during a frame.
- Sits between a DMA/AXIS source and an LED-strip/one-wire style pad.

Parameters:
- COUNTER_WIDTH, 16: width of period/duty/gap counters.
- DATA_AXIS_DATA_WIDTH, 8: bits per data word, all transmitted.
- CFG_AXIS_DATA_WIDTH, COUNTER_WIDTH: config tdata width; only the low COUNTER_WIDTH bits are used.
- MSB_FIRST, 1: 1 = bit DATA_AXIS_DATA_WIDTH-1 sent first, 0 = bit 0 first.
- IDLE_LEVEL, 0: `txd` level when idle and in the inactive part of a bit; active level = ~IDLE_LEVEL.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- txd  out  1  encoded serial output
- busy  out  1  high in BIT or GAP state
- underrun  out  1  one-cycle pulse when a non-last word ends with no next word available
- data_s_axis_tdata  in  DATA_AXIS_DATA_WIDTH  word to send
- data_s_axis_tlast  in  1  last word of frame
- data_s_axis_tvalid  in  1
- data_s_axis_tready  out  1
- cfg_period_s_axis_tdata / _tvalid / _tready  in/in/out  CFG_AXIS_DATA_WIDTH/1/1  bit period, in cycles
- cfg_duty_hi_s_axis_tdata / _tvalid / _tready  same  active cycles for a '1' bit
- cfg_duty_lo_s_axis_tdata / _tvalid / _tready  same  active cycles for a '0' bit
- cfg_gap_s_axis_tdata / _tvalid / _tready  same  idle-level cycles after a `tlast` word

Behaviour:
- Reset (async, while aresetn=0):
  - `txd` = IDLE_LEVEL; `busy`, `underrun` and all treadys = 0.
  - period, duty_hi, duty_lo and gap registers = 0; state = IDLE.
- Config channels:
  - Each cfg tready = 1 only in IDLE; a handshake loads the register at that edge.
  - During BIT/GAP all cfg treadys = 0 and valids stall.
  - A cfg and data handshake on the same edge: the new config applies to that frame.
- Data tready:
  - = 1 in IDLE when period != 0. With period = 0, data is never accepted.
  - In BIT: = 1 only on the last cycle of the last bit of a word whose latched tlast = 0.
  - 0 otherwise.
- States:
  - IDLE: `txd` = IDLE_LEVEL. A data handshake latches the word and tlast; next state is BIT with bit index 0 and count 0.
  - BIT: count runs 0..period-1. `txd` = active while count < duty(bit), else IDLE_LEVEL.
    - Duty >= period gives active for the whole bit; duty = 0 gives inactive for the whole bit.
    - At count = period-1 with more bits left: next bit, count 0.
    - At the last bit and count = period-1:
      - latched tlast = 1: GAP if gap != 0, else IDLE.
      - latched tlast = 0 and a handshake occurs: load the new word, stay in BIT with bit 0 and count 0 (zero idle cycles between words).
      - latched tlast = 0 and tvalid = 0: pulse `underrun` for one cycle and go to IDLE (no gap).
  - GAP: `txd` = IDLE_LEVEL for exactly gap cycles, then IDLE.
- Timing and arithmetic:
  - `txd` is registered. Bit 0 / count 0 appears on `txd` in the cycle immediately after the handshake edge.
  - A word occupies exactly DATA_AXIS_DATA_WIDTH*period cycles.
  - Counters are unsigned COUNTER_WIDTH; compares are unsigned; no wrap inside a bit.
  - Config registers hold their values across frames.
- Reset mid-frame: `txd` goes to IDLE_LEVEL immediately (async). The word in flight is discarded and all config is cleared to 0.

Test Plan:
- period=100, hi=75, lo=25, gap=50, MSB_FIRST=1, single word 0xCC tlast=1 -> `txd` active 75/idle 25 for bits 1,1; active 25/idle 75 for 0,0; repeated for 1,1,0,0. `busy` high 850 cycles, then IDLE and tready=1.
- Two words 0xF0 (tlast=0) and 0x0F (tlast=1) with tvalid held -> second handshake on cycle 799 of the frame; 1600 contiguous bit cycles, no idle cycle between words; `underrun` stays 0.
- Word 0xAA tlast=0 with no follow-up -> `underrun` pulses one cycle at end of bit 7; IDLE next cycle; no gap.
- Config checks:
  - hi=120, lo=0, period=100, word 0x80 -> bit 7 fully active for 100 cycles, bits 6..0 fully idle.
  - period=0 -> data tready stays 0 indefinitely.
- cfg_period tvalid with 50 during a frame -> tready 0 until IDLE. Accepted on the first IDLE cycle; the next frame uses period 50. MSB_FIRST=0 build, word 0x01 -> first bit is a '1'.
- aresetn low at cycle 300 of a frame -> `txd` = IDLE_LEVEL the same cycle and `busy` = 0. After release, data tready stays 0 until period is reprogrammed.
